lms_rx_iq_deframer: RTL and testbench



---
 rtl/lms_rx_iq_deframer.sv | 112 +++++++++++
 tb/tb_lms_rx_iq_deframer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/lms_rx_iq_deframer.sv
// lms_rx_iq_deframer: pairs interleaved LMS6002D RX I/Q words into strobed samples with IQSEL lock checking
// Ports:
//   lms_clk, rst_n        - sample clock (2x complex rate), async active-low reset
//   enable                - low forces HUNT, holds adc_a/adc_b, suppresses strobes
//   fmt_offset            - invert word MSB (offset binary -> two's complement)
//   swap_iq               - exchange I and Q on adc_a/adc_b
//   err_clr               - synchronous clear of err_cnt (wins over increment)
//   rx_iqsel, rx_d        - registered IQSEL (1 = I word) and 12-bit ADC word
//   adc_a, adc_b          - I/Q pair (Q/I when swap_iq), updated only on strobe
//   adc_strobe            - one-cycle pulse per new pair
//   locked, framing_err   - lock state and one-cycle loss-of-lock pulse
//   err_cnt               - saturating count of lock losses
module lms_rx_iq_deframer #(
    parameter int LOCK_CNT = 8,
    parameter int ERR_W    = 16
) (
    input  logic             lms_clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fmt_offset,
    input  logic             swap_iq,
    input  logic             err_clr,
    input  logic             rx_iqsel,
    input  logic [11:0]      rx_d,
    output logic [11:0]      adc_a,
    output logic [11:0]      adc_b,
    output logic             adc_strobe,
    output logic             locked,
    output logic             framing_err,
    output logic [ERR_W-1:0] err_cnt
);
    typedef enum logic {HUNT, LOCKED} state_t;
    state_t           state_q, state_d;
    logic             prev_iqsel_q;
    logic [7:0]       alt_cnt_q, alt_cnt_d;
    logic [8:0]       alt_inc;
    logic [11:0]      i_hold_q, i_hold_d, w;
    logic [11:0]      adc_a_q, adc_a_d, adc_b_q, adc_b_d;
    logic             adc_strobe_q, adc_strobe_d;
    logic             framing_err_q, framing_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             alt;

    always_comb begin
        w             = fmt_offset ? {~rx_d[11], rx_d[10:0]} : rx_d;
        alt           = rx_iqsel != prev_iqsel_q;
        alt_inc       = {1'b0, alt_cnt_q} + 9'd1;
        i_hold_d      = rx_iqsel ? w : i_hold_q;
        state_d       = state_q;
        alt_cnt_d     = alt_cnt_q;
        adc_a_d       = adc_a_q;
        adc_b_d       = adc_b_q;
        adc_strobe_d  = 1'b0;
        framing_err_d = 1'b0;
        err_cnt_d     = err_cnt_q;
        if (!enable) begin
            state_d   = HUNT;
            alt_cnt_d = '0;
        end else if (state_q == HUNT) begin
            if (!alt) begin
                alt_cnt_d = '0;
            end else if (alt_inc == 9'(LOCK_CNT)) begin
                state_d   = LOCKED;
                alt_cnt_d = '0;
            end else begin
                alt_cnt_d = alt_inc[7:0];
            end
        end else if (!alt) begin
            state_d       = HUNT;
            alt_cnt_d     = '0;
            framing_err_d = 1'b1;
            err_cnt_d     = &err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1;
        end else if (!rx_iqsel) begin
            // Q word completes the pair with the I word held from the previous cycle
            adc_a_d      = swap_iq ? w : i_hold_q;
            adc_b_d      = swap_iq ? i_hold_q : w;
            adc_strobe_d = 1'b1;
        end
        if (err_clr) err_cnt_d = '0;
    end

    always_ff @(posedge lms_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            prev_iqsel_q  <= 1'b0;
            alt_cnt_q     <= '0;
            i_hold_q      <= '0;
            adc_a_q       <= '0;
            adc_b_q       <= '0;
            adc_strobe_q  <= 1'b0;
            framing_err_q <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            prev_iqsel_q  <= rx_iqsel;
            alt_cnt_q     <= alt_cnt_d;
            i_hold_q      <= i_hold_d;
            adc_a_q       <= adc_a_d;
            adc_b_q       <= adc_b_d;
            adc_strobe_q  <= adc_strobe_d;
            framing_err_q <= framing_err_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign adc_a       = adc_a_q;
    assign adc_b       = adc_b_q;
    assign adc_strobe  = adc_strobe_q;
    assign locked      = state_q == LOCKED;
    assign framing_err = framing_err_q;
    assign err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_lms_rx_iq_deframer.sv
// tb_lms_rx_iq_deframer: directed stimulus with a cycle model and literal spot checks for lms_rx_iq_deframer
module tb_lms_rx_iq_deframer;
    localparam int LOCK  = 8;
    localparam int ERR_W = 4;
    localparam int EMAX  = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             enable = 1'b1;
    logic             fmt_offset = 1'b0;
    logic             swap_iq = 1'b0;
    logic             err_clr = 1'b0;
    logic             rx_iqsel = 1'b0;
    logic [11:0]      rx_d = '0;
    logic [11:0]      adc_a, adc_b;
    logic             adc_strobe, locked, framing_err;
    logic [ERR_W-1:0] err_cnt;

    int total = 0;
    int bad   = 0;

    lms_rx_iq_deframer #(.LOCK_CNT(LOCK), .ERR_W(ERR_W)) dut (
        .lms_clk(clk), .rst_n(rst_n), .enable(enable), .fmt_offset(fmt_offset),
        .swap_iq(swap_iq), .err_clr(err_clr), .rx_iqsel(rx_iqsel), .rx_d(rx_d),
        .adc_a(adc_a), .adc_b(adc_b), .adc_strobe(adc_strobe), .locked(locked),
        .framing_err(framing_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts a run of alternating IQSEL samples, declares lock
    // once the run reaches LOCK, and emits the held I with each following Q.
    logic [11:0] m_a, m_b, m_ihold, m_w;
    logic        m_strobe, m_ferr, m_locked, m_prev;
    int          m_err, m_run;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_ihold = 0; m_strobe = 0; m_ferr = 0;
            m_locked = 0; m_prev = 0; m_err = 0; m_run = 0;
        end else begin
            m_w      = fmt_offset ? (rx_d ^ 12'h800) : rx_d;
            m_strobe = 0;
            m_ferr   = 0;
            if (!enable) begin
                m_locked = 0;
                m_run    = 0;
            end else if (!m_locked) begin
                m_run = (rx_iqsel != m_prev) ? m_run + 1 : 0;
                if (m_run == LOCK) begin
                    m_locked = 1;
                    m_run    = 0;
                end
            end else if (rx_iqsel == m_prev) begin
                m_locked = 0;
                m_run    = 0;
                m_ferr   = 1;
                m_err    = (m_err < EMAX) ? m_err + 1 : EMAX;
            end else if (!rx_iqsel) begin
                m_a      = swap_iq ? m_w : m_ihold;
                m_b      = swap_iq ? m_ihold : m_w;
                m_strobe = 1;
            end
            if (err_clr) m_err = 0;
            if (rx_iqsel) m_ihold = m_w;
            m_prev = rx_iqsel;
        end
    end

    logic last_strobe = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_adc_a", 32'(adc_a), 32'(m_a));
            chk("cyc_adc_b", 32'(adc_b), 32'(m_b));
            chk("cyc_strobe", 32'(adc_strobe), 32'(m_strobe));
            chk("cyc_locked", 32'(locked), 32'(m_locked));
            chk("cyc_framing_err", 32'(framing_err), 32'(m_ferr));
            chk("cyc_err_cnt", 32'(err_cnt), 32'(m_err));
            chk("strobe_not_back_to_back", 32'(adc_strobe & last_strobe), 32'd0);
        end
        last_strobe = adc_strobe;
    end

    task automatic send(input logic sel, input logic [11:0] d);
        rx_iqsel = sel;
        rx_d     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [11:0] i, input logic [11:0] q);
        send(1'b1, i);
        send(1'b0, q);
    endtask

    // Called right after a glitch (prev IQSEL = 1): Q + 3 pairs + I = 8 alternations.
    task automatic relock_after_glitch();
        send(1'b0, 12'h456);
        repeat (3) pair(12'h123, 12'h456);
        send(1'b1, 12'h123);
    endtask

    task automatic lock_from_hunt(input string tag);
        repeat (3) pair(12'h123, 12'h456);
        send(1'b1, 12'h123);
        chk({tag, "_not_locked_at_7"}, 32'(locked), 32'd0);
        send(1'b0, 12'h456);
        chk({tag, "_locked_at_8"}, 32'(locked), 32'd1);
        chk({tag, "_no_strobe_at_lock"}, 32'(adc_strobe), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_adc_a", 32'(adc_a), 32'd0);
        chk("rst_adc_b", 32'(adc_b), 32'd0);
        chk("rst_strobe", 32'(adc_strobe), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_framing_err", 32'(framing_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        lock_from_hunt("lock1");
        send(1'b1, 12'h123);
        chk("lock1_i_no_strobe", 32'(adc_strobe), 32'd0);
        send(1'b0, 12'h456);
        chk("lock1_strobe", 32'(adc_strobe), 32'd1);
        chk("lock1_adc_a", 32'(adc_a), 32'h123);
        chk("lock1_adc_b", 32'(adc_b), 32'h456);
        pair(12'h123, 12'h456);
        chk("lock1_err_cnt", 32'(err_cnt), 32'd0);

        send(1'b1, 12'h123);
        send(1'b1, 12'h123);
        chk("glitch_ferr", 32'(framing_err), 32'd1);
        chk("glitch_locked", 32'(locked), 32'd0);
        chk("glitch_err_cnt", 32'(err_cnt), 32'd1);
        chk("glitch_no_strobe", 32'(adc_strobe), 32'd0);
        relock_after_glitch();
        chk("relock_locked", 32'(locked), 32'd1);
        send(1'b0, 12'h456);
        chk("relock_strobe", 32'(adc_strobe), 32'd1);

        fmt_offset = 1'b1;
        pair(12'h800, 12'h7FF);
        chk("fmt_adc_a", 32'(adc_a), 32'h000);
        chk("fmt_adc_b", 32'(adc_b), 32'hFFF);
        swap_iq = 1'b1;
        pair(12'h800, 12'h7FF);
        chk("swap_adc_a", 32'(adc_a), 32'hFFF);
        chk("swap_adc_b", 32'(adc_b), 32'h000);
        fmt_offset = 1'b0;
        swap_iq    = 1'b0;
        pair(12'h123, 12'h456);

        repeat (EMAX + 1) begin
            send(1'b1, 12'h123);
            send(1'b1, 12'h123);
            relock_after_glitch();
        end
        chk("sat_err_cnt", 32'(err_cnt), 32'(EMAX));
        send(1'b1, 12'h123);
        chk("sat_hold_err_cnt", 32'(err_cnt), 32'(EMAX));
        relock_after_glitch();
        err_clr = 1'b1;
        send(1'b1, 12'h123);
        err_clr = 1'b0;
        chk("clr_wins_err_cnt", 32'(err_cnt), 32'd0);
        chk("clr_glitch_ferr", 32'(framing_err), 32'd1);
        relock_after_glitch();
        send(1'b0, 12'h456);
        chk("pre_dis_adc_a", 32'(adc_a), 32'h123);

        enable = 1'b0;
        send(1'b1, 12'hAAA);
        chk("dis_locked", 32'(locked), 32'd0);
        chk("dis_strobe", 32'(adc_strobe), 32'd0);
        chk("dis_ferr", 32'(framing_err), 32'd0);
        send(1'b0, 12'hBBB);
        chk("dis_hold_a", 32'(adc_a), 32'h123);
        chk("dis_hold_b", 32'(adc_b), 32'h456);
        chk("dis_err_cnt", 32'(err_cnt), 32'd0);
        enable = 1'b1;
        lock_from_hunt("reen");
        pair(12'h321, 12'h654);
        chk("reen_adc_a", 32'(adc_a), 32'h321);
        chk("reen_adc_b", 32'(adc_b), 32'h654);

        send(1'b1, 12'h123);
        send(1'b1, 12'h123);
        chk("pre_rst_err_cnt", 32'(err_cnt), 32'd1);
        relock_after_glitch();
        send(1'b0, 12'h456);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_adc_a", 32'(adc_a), 32'd0);
        chk("arst_adc_b", 32'(adc_b), 32'd0);
        chk("arst_strobe", 32'(adc_strobe), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        lock_from_hunt("post_rst");
        pair(12'h123, 12'h456);
        chk("post_rst_strobe", 32'(adc_strobe), 32'd1);
        chk("post_rst_adc_a", 32'(adc_a), 32'h123);
        chk("post_rst_adc_b", 32'(adc_b), 32'h456);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
